// File: rtl/ratio_to_fixed_point_pkg.sv
// Shared constants and state encoding for the ratio-to-fixed-point converter.
package ratio_to_fixed_point_pkg;

    localparam int FRAC_SCALE = 100000;
    localparam int NUM_W      = 21;
    localparam int X_W        = 10;
    localparam int Y_W        = 18;
    localparam int PROD_W     = 38;
    localparam int F_BITS     = 17;
    localparam int SAT_X      = 511;
    localparam int SAT_Y      = 99999;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INT  = 2'd1,
        S_FRAC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's-complement magnitude; -2^20 maps to 2^20 as an unsigned value.
    function automatic logic [NUM_W-1:0] mag(input logic [NUM_W-1:0] v);
        return v[NUM_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/udiv_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, subtract.
module udiv_step
    import ratio_to_fixed_point_pkg::*;
(
    input  logic [NUM_W-1:0] rem,
    input  logic             in_bit,
    input  logic [NUM_W-1:0] divisor,
    output logic [NUM_W-1:0] rem_next,
    output logic             q_bit
);

    logic [NUM_W:0] trial;

    assign trial    = {rem, in_bit};
    assign q_bit    = (trial >= {1'b0, divisor});
    // The partial remainder stays below the divisor, so NUM_W bits suffice.
    assign rem_next = q_bit ? NUM_W'(trial - {1'b0, divisor}) : trial[NUM_W-1:0];

endmodule

// File: rtl/ratio_to_fixed_point.sv
// Converts num/den into a signed integer part and a 5-digit decimal fraction.
module ratio_to_fixed_point #(
    parameter int FRAC_SCALE = ratio_to_fixed_point_pkg::FRAC_SCALE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic signed [20:0] num,
    input  logic signed [20:0] den,
    output logic               busy,
    output logic               done,
    output logic signed [9:0]  fixed_X,
    output logic signed [17:0] fixed_Y,
    output logic               overflow,
    output logic               div_by_zero,
    output logic [1:0]         fsm_state
);
    import ratio_to_fixed_point_pkg::*;

    state_t                state;
    logic [4:0]            cnt;
    logic                  neg;
    logic [NUM_W-1:0]      den_mag;
    logic [NUM_W-1:0]      quo;
    logic [NUM_W-1:0]      rem;
    logic [F_BITS-1:0]     fbits;

    logic                  step_in;
    logic [NUM_W-1:0]      rem_next;
    logic                  q_bit;
    logic [PROD_W-1:0]     scaled;
    logic                  q_over;
    logic signed [X_W-1:0] x_mag;
    logic signed [Y_W-1:0] y_mag;
    logic signed [X_W-1:0] sat_x;
    logic signed [Y_W-1:0] sat_y;

    assign step_in = (state == S_INT) ? quo[NUM_W-1] : fbits[F_BITS-1];

    udiv_step u_step (
        .rem      (rem),
        .in_bit   (step_in),
        .divisor  (den_mag),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // The high part of r*scale is always below |den|, so it seeds the fraction remainder.
    assign scaled = PROD_W'(rem_next) * PROD_W'(FRAC_SCALE);
    assign q_over = |quo[NUM_W-1:9];
    assign x_mag  = {1'b0, quo[8:0]};
    assign y_mag  = {1'b0, fbits};
    assign sat_x  = X_W'(SAT_X);
    assign sat_y  = Y_W'(SAT_Y);

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            neg         <= 1'b0;
            den_mag     <= '0;
            quo         <= '0;
            rem         <= '0;
            fbits       <= '0;
            done        <= 1'b0;
            fixed_X     <= '0;
            fixed_Y     <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        neg     <= num[NUM_W-1] ^ den[NUM_W-1];
                        quo     <= mag(num);
                        den_mag <= mag(den);
                        rem     <= '0;
                        fbits   <= '0;
                        cnt     <= '0;
                        state   <= S_INT;
                    end
                end
                S_INT: begin
                    quo <= {quo[NUM_W-2:0], q_bit};
                    if (cnt == 5'd20) begin
                        rem   <= scaled[PROD_W-1:F_BITS];
                        fbits <= scaled[F_BITS-1:0];
                        cnt   <= '0;
                        state <= S_FRAC;
                    end else begin
                        rem <= rem_next;
                        cnt <= cnt + 5'd1;
                    end
                end
                S_FRAC: begin
                    if (cnt == 5'd17) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                        if (den_mag == '0) begin
                            fixed_X     <= sat_x;
                            fixed_Y     <= sat_y;
                            overflow    <= 1'b0;
                            div_by_zero <= 1'b1;
                        end else if (q_over) begin
                            fixed_X     <= neg ? -sat_x : sat_x;
                            fixed_Y     <= neg ? -sat_y : sat_y;
                            overflow    <= 1'b1;
                            div_by_zero <= 1'b0;
                        end else begin
                            fixed_X     <= neg ? -x_mag : x_mag;
                            fixed_Y     <= neg ? -y_mag : y_mag;
                            overflow    <= 1'b0;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        rem   <= rem_next;
                        fbits <= {fbits[F_BITS-2:0], q_bit};
                        cnt   <= cnt + 5'd1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ratio_to_fixed_point.md
RATIO_TO_FIXED_POINT -- requirements
Module: ratio_to_fixed_point

Interface
REQ-001 The block SHALL provide: clock  input  1  sole clock; all state updates on the rising edge.
REQ-002 The block SHALL provide: reset  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL provide: start  input  1  request pulse; sampled only while busy==0.
REQ-004 The block SHALL provide: num  input  21 signed  numerator, an integer.
REQ-005 The block SHALL provide: den  input  21 signed  denominator, an integer.
REQ-006 The block SHALL provide: busy  output  1  high in every state except IDLE.
REQ-007 The block SHALL provide: done  output  1  one-cycle pulse; result valid.
REQ-008 The block SHALL provide: fixed_X  output  10 signed  integer part of num/den.
REQ-009 The block SHALL provide: fixed_Y  output  18 signed  fraction part, decimal digits × 10^5, range −99999..99999.
REQ-010 The block SHALL provide: overflow  output  1  set when the magnitude of the integer part exceeds 511.
REQ-011 The block SHALL provide: div_by_zero  output  1  set when den==0.
REQ-012 The block SHALL provide: parameter FRAC_SCALE, default 100000, the fraction scale (5 decimal places).

Function
REQ-013 Result encoding SHALL be value = fixed_X + fixed_Y/100000, truncated toward zero; fixed_X and fixed_Y SHALL carry the sign of the quotient, or be zero.
REQ-014 The states SHALL be IDLE → INT → FRAC → DONE → IDLE.
REQ-015 start high in IDLE at edge k SHALL latch the magnitudes |num| and |den|, latch the result sign (num sign XOR den sign), and enter INT.
REQ-016 start SHALL be ignored whenever busy==1; inputs SHALL NOT be re-sampled after edge k.
REQ-017 INT SHALL perform 21 unsigned restoring-division iterations (edges k+1..k+21), giving integer quotient q and remainder r.
REQ-018 FRAC SHALL divide r×FRAC_SCALE (a 38-bit value) by |den| over 17 restoring iterations (edges k+22..k+38), giving f, with 0 ≤ f ≤ 99999.
REQ-019 Edge k+39 SHALL register fixed_X, fixed_Y, overflow and div_by_zero, enter DONE, and drive done=1 for exactly that cycle.
REQ-020 Edge k+40 SHALL return the block to IDLE; a new start is accepted from edge k+40 onward.
REQ-021 Latency SHALL be fixed at 39 edges for all inputs, including error cases.
REQ-022 For den==0: fixed_X=+511, fixed_Y=+99999, div_by_zero=1 and overflow=0, regardless of the sign of num.
REQ-023 For q>511: fixed_X=±511, fixed_Y=±99999 (with the quotient's sign) and overflow=1.
REQ-024 For num==0: fixed_X=0, fixed_Y=0, and neither flag set.
REQ-025 num = −2^20 SHALL be handled correctly, with its magnitude held as an unsigned 21-bit value.
REQ-026 fixed_X, fixed_Y and the flags SHALL hold their values until the next result is registered.

Reset
REQ-027 On reset (asynchronous): state=IDLE; busy=0, done=0, fixed_X=0, fixed_Y=0, overflow=0, div_by_zero=0; all datapath registers cleared.
REQ-028 Reset mid-operation SHALL abort the computation with no done pulse; the first start after reset is released SHALL behave as from power-up.

Structure
REQ-029 The shared package SHALL hold FRAC_SCALE, the widths (21, 10, 18), SAT_X=511, SAT_Y=99999 and the state encoding.
REQ-030 A single sub-module, udiv_step, SHALL implement one shift/compare/subtract iteration and be reused by both INT and FRAC.
REQ-031 All arithmetic SHALL be synthesizable integer logic, with no real-number system functions.

Verification
REQ-032 The bench SHALL cover: num=5, den=2 → fixed_X=2, fixed_Y=50000, done exactly 39 edges after the start edge.
REQ-033 The bench SHALL cover: num=1, den=160 → fixed_X=0, fixed_Y=625; num=1, den=3 → fixed_X=0, fixed_Y=33333.
REQ-034 The bench SHALL cover: num=−7, den=2 → fixed_X=−3, fixed_Y=−50000; num=7, den=−2 → the same result.
REQ-035 The bench SHALL cover: num=1000, den=1 → fixed_X=511, fixed_Y=99999, overflow=1; num=3, den=0 → fixed_X=511, fixed_Y=99999, div_by_zero=1.
REQ-036 The bench SHALL cover: start pulsed again while busy → ignored, with a single done pulse.
REQ-037 The bench SHALL cover: reset asserted at edge k+20 → no done pulse and all outputs 0; a following start with num=9, den=4 → fixed_X=2, fixed_Y=25000.
